csr_file: RTL

CSR_FILE -- requirements
Module: csr_file

---
 rtl/csr_file.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR file: mstatus, mie, mtvec, mepc, mcause, mip, plus trap entry and MRET.
// Define CSR_MCYCLE_EN to add the 64-bit mcycle/mcycleh counter at 0xB00/0xB80.
module csr_file #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          csr_en,
  input  logic [1:0]    csr_op,
  input  logic [11:0]   csr_addr,
  input  logic [DW-1:0] csr_wdata,
  output logic [DW-1:0] csr_rdata,
  output logic          csr_illegal,
  input  logic          timer_irq,
  input  logic          ext_irq,
  input  logic          trap_take,
  input  logic [DW-1:0] trap_pc,
  input  logic          is_mret,
  output logic [DW-1:0] mstatus_reg,
  output logic [DW-1:0] mie_reg,
  output logic [DW-1:0] mtvec_reg,
  output logic [DW-1:0] mepc_reg,
  output logic [DW-1:0] mcause_reg,
  output logic [DW-1:0] mip_reg
);

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [DW-1:0] MSTATUS_FIXED = 32'h0000_1800;  // MPP hardwired to M-mode
  localparam logic [DW-1:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [DW-1:0] MIE_BIT       = 32'h0000_0008;
  localparam logic [DW-1:0] MPIE_BIT      = 32'h0000_0080;
  localparam logic [DW-1:0] MIE_WMASK     = 32'h0000_0880;
  localparam logic [DW-1:0] MTVEC_WMASK   = 32'hFFFF_FFFD;
  localparam logic [DW-1:0] MEPC_WMASK    = 32'hFFFF_FFFC;
  localparam logic [DW-1:0] CAUSE_EXT     = 32'h8000_000B;
  localparam logic [DW-1:0] CAUSE_TIMER   = 32'h8000_0007;

  logic [DW-1:0] mstatus_q, mie_q, mtvec_q, mepc_q, mcause_q, mip_q;
  logic [DW-1:0] mip_next;
  logic [DW-1:0] old_val, new_val;
  logic          addr_mapped;
  logic          write_req, csr_we;
  csr_op_e       op;

`ifdef CSR_MCYCLE_EN
  localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;
  logic [63:0] mcycle_q;
`endif

  assign op = csr_op_e'(csr_op);

  // NOTE: every variable assigned here gets a default first, so no path leaves a latch.
  always_comb begin
    addr_mapped = 1'b1;
    old_val     = '0;
    case (csr_addr)
      ADDR_MSTATUS: old_val = mstatus_q;
      ADDR_MIE:     old_val = mie_q;
      ADDR_MTVEC:   old_val = mtvec_q;
      ADDR_MEPC:    old_val = mepc_q;
      ADDR_MCAUSE:  old_val = mcause_q;
      ADDR_MIP:     old_val = mip_q;
`ifdef CSR_MCYCLE_EN
      ADDR_MCYCLE:  old_val = mcycle_q[31:0];
      ADDR_MCYCLEH: old_val = mcycle_q[63:32];
`endif
      default:      addr_mapped = 1'b0;
    endcase
  end

  always_comb begin
    new_val = old_val;
    case (op)
      OP_RW:   new_val = csr_wdata;
      OP_RS:   new_val = old_val | csr_wdata;
      OP_RC:   new_val = old_val & ~csr_wdata;
      default: new_val = old_val;
    endcase
  end

  always_comb begin
    mip_next     = '0;
    mip_next[7]  = timer_irq;
    mip_next[11] = ext_irq;
  end

  // Set/clear with a zero operand is a pure read; traps and MRET pre-empt any write.
  assign write_req = csr_en && (op != OP_NONE) && addr_mapped &&
                     !(((op == OP_RS) || (op == OP_RC)) && (csr_wdata == '0));
  assign csr_we    = write_req && !trap_take && !is_mret;

  assign csr_rdata   = old_val;
  assign csr_illegal = csr_en && !addr_mapped;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q <= MSTATUS_FIXED;
      mie_q     <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
      mip_q     <= '0;
    end else begin
      mip_q <= mip_next;
      if (trap_take) begin
        mepc_q    <= trap_pc & MEPC_WMASK;
        mstatus_q <= MSTATUS_FIXED | (mstatus_q[3] ? MPIE_BIT : '0);
        mcause_q  <= (mip_q[11] && mie_q[11]) ? CAUSE_EXT : CAUSE_TIMER;
      end else if (is_mret) begin
        mstatus_q <= MSTATUS_FIXED | MPIE_BIT | (mstatus_q[7] ? MIE_BIT : '0);
      end else if (csr_we) begin
        case (csr_addr)
          ADDR_MSTATUS: mstatus_q <= (mstatus_q & ~MSTATUS_WMASK) | (new_val & MSTATUS_WMASK);
          ADDR_MIE:     mie_q     <= new_val & MIE_WMASK;
          ADDR_MTVEC:   mtvec_q   <= new_val & MTVEC_WMASK;
          ADDR_MEPC:    mepc_q    <= new_val & MEPC_WMASK;
          ADDR_MCAUSE:  mcause_q  <= new_val;
          default:      ;
        endcase
      end
    end
  end

`ifdef CSR_MCYCLE_EN
  // A write to one half replaces it for that edge; the counter skips its increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q <= '0;
    end else if (csr_we && (csr_addr == ADDR_MCYCLE)) begin
      mcycle_q[31:0] <= new_val;
    end else if (csr_we && (csr_addr == ADDR_MCYCLEH)) begin
      mcycle_q[63:32] <= new_val;
    end else begin
      mcycle_q <= mcycle_q + 64'd1;
    end
  end
`endif

  assign mstatus_reg = mstatus_q;
  assign mie_reg     = mie_q;
  assign mtvec_reg   = mtvec_q;
  assign mepc_reg    = mepc_q;
  assign mcause_reg  = mcause_q;
  assign mip_reg     = mip_q;

endmodule
